// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: DMCtrl access-type codes, splitter state, byte-count helper.
package lsu_pkg;

   localparam logic [2:0] DM_B  = 3'b000;
   localparam logic [2:0] DM_H  = 3'b001;
   localparam logic [2:0] DM_W  = 3'b010;
   localparam logic [2:0] DM_BU = 3'b100;
   localparam logic [2:0] DM_HU = 3'b101;

   typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} mau_state_t;

   function automatic logic [2:0] bytes_for(input logic [2:0] ctrl);
      case (ctrl)
         DM_H, DM_HU: bytes_for = 3'd2;
         DM_W:        bytes_for = 3'd4;
         default:     bytes_for = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of assembled load bytes according to DMCtrl.
// Purely combinational; no state, no backpressure.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] i_raw,
   input  logic [2:0]  i_ctrl,
   output logic [31:0] o_data
);

   always_comb begin
      case (i_ctrl)
         DM_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
         DM_BU:   o_data = {24'h0, i_raw[7:0]};
         DM_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
         DM_HU:   o_data = {16'h0, i_raw[15:0]};
         default: o_data = i_raw;
      endcase
   end

endmodule

// File: rtl/misaligned_access_unit.sv
// Splits misaligned H/W loads/stores into byte accesses; aligned traffic passes through in zero cycles.
// Misaligned access takes N cycles with Stall high for the first N-1; core must hold its request while stalled.
module misaligned_access_unit
   import lsu_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic        DMWr,
   input  logic        DMRd,
   input  logic [2:0]  DMCtrl,
   output logic [31:0] MemAddress,
   output logic [31:0] MemDataWr,
   output logic        MemDMWr,
   output logic [2:0]  MemDMCtrl,
   input  logic [31:0] MemDataRd,
   output logic [31:0] DataRd,
   output logic        Stall,
   output logic        Misaligned
);

   mau_state_t  r_state, w_state_nxt;
   logic [1:0]  r_k;
   logic [31:0] r_base;
   logic [31:0] r_data;
   logic [2:0]  r_ctrl;
   logic        r_store;
   logic [23:0] r_buf;

   logic        w_load, w_req, w_mis, w_start, w_last;
   logic [2:0]  w_n;
   logic [7:0]  w_wbyte;
   logic [31:0] w_raw, w_ext;

   assign w_load  = ~DMWr & DMRd;
   assign w_req   = DMWr | DMRd;
   assign w_mis   = w_req & (((DMCtrl == DM_H || DMCtrl == DM_HU) && Address[0]) ||
                             (DMCtrl == DM_W && Address[1:0] != 2'b00));
   assign w_start = SPLIT_EN && (r_state == IDLE) && w_mis;
   assign w_n     = bytes_for(r_ctrl);
   assign w_last  = ({1'b0, r_k} == (w_n - 3'd1));

   always_comb begin
      case (r_k)
         2'd0:    w_wbyte = r_data[7:0];
         2'd1:    w_wbyte = r_data[15:8];
         2'd2:    w_wbyte = r_data[23:16];
         default: w_wbyte = r_data[31:24];
      endcase
   end

   // The final byte comes straight from memory this cycle; earlier bytes come from the buffer.
   assign w_raw = (w_n == 3'd2) ? {16'h0, MemDataRd[7:0], r_buf[7:0]}
                                : {MemDataRd[7:0], r_buf};

   load_extend u_load_extend (
      .i_raw  (w_raw),
      .i_ctrl (r_ctrl),
      .o_data (w_ext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start) w_state_nxt = SPLIT;
         SPLIT:   if (w_last)  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_k     <= 2'd0;
         r_base  <= 32'h0;
         r_data  <= 32'h0;
         r_ctrl  <= 3'b000;
         r_store <= 1'b0;
         r_buf   <= 24'h0;
      end else if (w_start) begin
         r_k     <= 2'd1;
         r_base  <= Address;
         r_data  <= DataWr;
         r_ctrl  <= DMCtrl;
         r_store <= DMWr;
         if (w_load) r_buf[7:0] <= MemDataRd[7:0];
      end else if (r_state == SPLIT) begin
         if (w_last) begin
            r_k <= 2'd0;
         end else begin
            r_k <= r_k + 2'd1;
            if (!r_store) begin
               case (r_k)
                  2'd1:    r_buf[15:8]  <= MemDataRd[7:0];
                  2'd2:    r_buf[23:16] <= MemDataRd[7:0];
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      MemAddress = Address;
      MemDataWr  = DataWr;
      MemDMWr    = DMWr;
      MemDMCtrl  = DMCtrl;
      DataRd     = MemDataRd;
      Stall      = 1'b0;
      Misaligned = w_mis;
      if (rst) begin
         MemDMWr    = 1'b0;
         DataRd     = 32'h0;
         Misaligned = 1'b0;
      end else if (r_state == SPLIT) begin
         MemAddress = r_base + {30'h0, r_k};
         MemDataWr  = {r_data[31:8], w_wbyte};
         MemDMWr    = r_store;
         MemDMCtrl  = r_store ? DM_B : DM_BU;
         Misaligned = 1'b1;
         Stall      = ~w_last;
         DataRd     = (w_last && !r_store) ? w_ext : 32'h0;
      end else if (w_start) begin
         MemDMCtrl  = DMWr ? DM_B : DM_BU;
         DataRd     = 32'h0;
         Stall      = 1'b1;
         Misaligned = 1'b1;
      end
   end

endmodule

// File: tb/tb_misaligned_access_unit.sv
// Directed bench: byte-addressed memory model, cycle-by-cycle vector table, reset and pass-through sequences.
module tb_misaligned_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Address, DataWr;
   logic        DMWr, DMRd;
   logic [2:0]  DMCtrl;
   logic        mem_init;

   logic [31:0] ma0, mwd0, mrd0, drd0, raw0;
   logic [2:0]  mc0;
   logic        mw0, stall0, mis0;
   logic [31:0] ma1, mwd1, mrd1, drd1, raw1;
   logic [2:0]  mc1;
   logic        mw1, stall1, mis1;

   logic [7:0]  mem [0:255];
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   misaligned_access_unit #(.SPLIT_EN(1'b1)) u0 (
      .clk(clk), .rst(rst), .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMRd(DMRd),
      .DMCtrl(DMCtrl), .MemAddress(ma0), .MemDataWr(mwd0), .MemDMWr(mw0), .MemDMCtrl(mc0),
      .MemDataRd(mrd0), .DataRd(drd0), .Stall(stall0), .Misaligned(mis0));

   misaligned_access_unit #(.SPLIT_EN(1'b0)) u1 (
      .clk(clk), .rst(rst), .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMRd(DMRd),
      .DMCtrl(DMCtrl), .MemAddress(ma1), .MemDataWr(mwd1), .MemDMWr(mw1), .MemDMCtrl(mc1),
      .MemDataRd(mrd1), .DataRd(drd1), .Stall(stall1), .Misaligned(mis1));

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] c);
      case (c)
         3'b000:  ext = {{24{w[7]}}, w[7:0]};
         3'b100:  ext = {24'h0, w[7:0]};
         3'b001:  ext = {{16{w[15]}}, w[15:0]};
         3'b101:  ext = {16'h0, w[15:0]};
         default: ext = w;
      endcase
   endfunction

   assign raw0 = {mem[ma0[7:0] + 8'd3], mem[ma0[7:0] + 8'd2], mem[ma0[7:0] + 8'd1], mem[ma0[7:0]]};
   assign raw1 = {mem[ma1[7:0] + 8'd3], mem[ma1[7:0] + 8'd2], mem[ma1[7:0] + 8'd1], mem[ma1[7:0]]};
   assign mrd0 = ext(raw0, mc0);
   assign mrd1 = ext(raw1, mc1);

   // Only the splitting instance commits stores; the pass-through instance is read-only.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h10] <= 8'h11; mem[8'h11] <= 8'h22; mem[8'h12] <= 8'h33; mem[8'h13] <= 8'h44;
         mem[8'h14] <= 8'h55; mem[8'h15] <= 8'h66; mem[8'h16] <= 8'h77; mem[8'h17] <= 8'h88;
         mem[8'h18] <= 8'h99; mem[8'h19] <= 8'hAA; mem[8'h1A] <= 8'hBB; mem[8'h1B] <= 8'hCC;
      end else if (mw0) begin
         mem[ma0[7:0]] <= mwd0[7:0];
         if (mc0 == 3'b001 || mc0 == 3'b010) mem[ma0[7:0] + 8'd1] <= mwd0[15:8];
         if (mc0 == 3'b010) begin
            mem[ma0[7:0] + 8'd2] <= mwd0[23:16];
            mem[ma0[7:0] + 8'd3] <= mwd0[31:24];
         end
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic        rd;
      logic [2:0]  ctrl;
      logic [31:0] e_maddr;
      logic [2:0]  e_mctrl;
      logic        e_mwr;
      logic        e_stall;
      logic        e_mis;
      logic        chk_rd;
      logic [31:0] e_rd;
      logic        chk_wb;
      logic [7:0]  e_wb;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                              input logic rd, input logic [2:0] c, input logic [31:0] ema,
                              input logic [2:0] emc, input logic emw, input logic est,
                              input logic emis, input logic crd, input logic [31:0] erd,
                              input logic cwb, input logic [7:0] ewb);
      vec_t r;
      r.addr = a; r.wdata = wd; r.wr = wr; r.rd = rd; r.ctrl = c;
      r.e_maddr = ema; r.e_mctrl = emc; r.e_mwr = emw; r.e_stall = est; r.e_mis = emis;
      r.chk_rd = crd; r.e_rd = erd; r.chk_wb = cwb; r.e_wb = ewb;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                        input logic rd, input logic [2:0] c);
      Address = a; DataWr = wd; DMWr = wr; DMRd = rd; DMCtrl = c;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      // Cycle-by-cycle vectors; the core holds each instruction while Stall is high.
      tbl.push_back(v(32'h10, 0, 0, 1, 3'b010, 32'h10, 3'b010, 0, 0, 0, 1, 32'h44332211, 0, 0));
      tbl.push_back(v(32'h13, 0, 0, 1, 3'b010, 32'h13, 3'b100, 0, 1, 1, 0, 32'h0, 0, 0));
      tbl.push_back(v(32'h13, 0, 0, 1, 3'b010, 32'h14, 3'b100, 0, 1, 1, 1, 32'h0, 0, 0));
      tbl.push_back(v(32'h13, 0, 0, 1, 3'b010, 32'h15, 3'b100, 0, 1, 1, 1, 32'h0, 0, 0));
      tbl.push_back(v(32'h13, 0, 0, 1, 3'b010, 32'h16, 3'b100, 0, 0, 1, 1, 32'h77665544, 0, 0));
      tbl.push_back(v(32'h17, 0, 0, 1, 3'b001, 32'h17, 3'b100, 0, 1, 1, 0, 32'h0, 0, 0));
      tbl.push_back(v(32'h17, 0, 0, 1, 3'b001, 32'h18, 3'b100, 0, 0, 1, 1, 32'hFFFF9988, 0, 0));
      tbl.push_back(v(32'h17, 0, 0, 1, 3'b101, 32'h17, 3'b100, 0, 1, 1, 0, 32'h0, 0, 0));
      tbl.push_back(v(32'h17, 0, 0, 1, 3'b101, 32'h18, 3'b100, 0, 0, 1, 1, 32'h00009988, 0, 0));
      tbl.push_back(v(32'h11, 0, 0, 1, 3'b001, 32'h11, 3'b100, 0, 1, 1, 0, 32'h0, 0, 0));
      tbl.push_back(v(32'h11, 0, 0, 1, 3'b001, 32'h12, 3'b100, 0, 0, 1, 1, 32'h00003322, 0, 0));
      tbl.push_back(v(32'h12, 32'hDEADBEEF, 1, 0, 3'b010, 32'h12, 3'b000, 1, 1, 1, 0, 0, 1, 8'hEF));
      tbl.push_back(v(32'h12, 32'hDEADBEEF, 1, 0, 3'b010, 32'h13, 3'b000, 1, 1, 1, 0, 0, 1, 8'hBE));
      tbl.push_back(v(32'h12, 32'hDEADBEEF, 1, 0, 3'b010, 32'h14, 3'b000, 1, 1, 1, 0, 0, 1, 8'hAD));
      tbl.push_back(v(32'h12, 32'hDEADBEEF, 1, 0, 3'b010, 32'h15, 3'b000, 1, 0, 1, 0, 0, 1, 8'hDE));
      tbl.push_back(v(32'h10, 0, 0, 1, 3'b010, 32'h10, 3'b010, 0, 0, 0, 1, 32'hBEEF2211, 0, 0));
      tbl.push_back(v(32'h14, 0, 0, 1, 3'b010, 32'h14, 3'b010, 0, 0, 0, 1, 32'h8877DEAD, 0, 0));
      tbl.push_back(v(32'hFFFFFFFE, 32'h01020304, 1, 0, 3'b010, 32'hFFFFFFFE, 3'b000, 1, 1, 1, 0, 0, 1, 8'h04));
      tbl.push_back(v(32'hFFFFFFFE, 32'h01020304, 1, 0, 3'b010, 32'hFFFFFFFF, 3'b000, 1, 1, 1, 0, 0, 1, 8'h03));
      tbl.push_back(v(32'hFFFFFFFE, 32'h01020304, 1, 0, 3'b010, 32'h00000000, 3'b000, 1, 1, 1, 0, 0, 1, 8'h02));
      tbl.push_back(v(32'hFFFFFFFE, 32'h01020304, 1, 0, 3'b010, 32'h00000001, 3'b000, 1, 0, 1, 0, 0, 1, 8'h01));

      // Reset state, with a misaligned store presented so the gating is visible.
      rst = 1'b1;
      mem_init = 1'b1;
      drive(32'h13, 32'h12345678, 1'b1, 1'b0, 3'b010);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst stall", {31'h0, stall0}, 32'h0);
      chk("rst misaligned", {31'h0, mis0}, 32'h0);
      chk("rst memdmwr", {31'h0, mw0}, 32'h0);
      chk("rst datard", drd0, 32'h0);
      chk("rst memaddress", ma0, 32'h13);
      chk("rst memdmctrl", {29'h0, mc0}, 32'h2);
      next_cycle();
      rst = 1'b0;
      mem_init = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].addr, tbl[i].wdata, tbl[i].wr, tbl[i].rd, tbl[i].ctrl);
         @(negedge clk);
         chk($sformatf("row%0d memaddress", i), ma0, tbl[i].e_maddr);
         chk($sformatf("row%0d memdmctrl", i), {29'h0, mc0}, {29'h0, tbl[i].e_mctrl});
         chk($sformatf("row%0d memdmwr", i), {31'h0, mw0}, {31'h0, tbl[i].e_mwr});
         chk($sformatf("row%0d stall", i), {31'h0, stall0}, {31'h0, tbl[i].e_stall});
         chk($sformatf("row%0d misaligned", i), {31'h0, mis0}, {31'h0, tbl[i].e_mis});
         if (tbl[i].chk_rd) chk($sformatf("row%0d datard", i), drd0, tbl[i].e_rd);
         if (tbl[i].chk_wb) chk($sformatf("row%0d wrbyte", i), {24'h0, mwd0[7:0]}, {24'h0, tbl[i].e_wb});
         next_cycle();
      end

      // Reset in the third cycle of a split store: bytes 0x12/0x13 stay, 0x14 is never written.
      drive(32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
      mem_init = 1'b1;
      next_cycle();
      mem_init = 1'b0;
      drive(32'h12, 32'hDEADBEEF, 1'b1, 1'b0, 3'b010);
      @(negedge clk);
      chk("abort c1 memaddress", ma0, 32'h12);
      chk("abort c1 stall", {31'h0, stall0}, 32'h1);
      next_cycle();
      @(negedge clk);
      chk("abort c2 memaddress", ma0, 32'h13);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("abort rst stall", {31'h0, stall0}, 32'h0);
      chk("abort rst memdmwr", {31'h0, mw0}, 32'h0);
      chk("abort rst misaligned", {31'h0, mis0}, 32'h0);
      next_cycle();
      rst = 1'b0;
      drive(32'h14, 32'h0, 1'b0, 1'b1, 3'b010);
      @(negedge clk);
      chk("post-rst lw14 stall", {31'h0, stall0}, 32'h0);
      chk("post-rst lw14 datard", drd0, 32'h88776655);
      next_cycle();
      drive(32'h10, 32'h0, 1'b0, 1'b1, 3'b010);
      @(negedge clk);
      chk("post-rst lw10 datard", drd0, 32'hBEEF2211);
      next_cycle();

      // Pass-through instance: misaligned LW flagged but issued as one word access, never stalls.
      drive(32'h13, 32'h0, 1'b0, 1'b1, 3'b010);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("nosplit c%0d stall", c), {31'h0, stall1}, 32'h0);
         chk($sformatf("nosplit c%0d misaligned", c), {31'h0, mis1}, 32'h1);
         chk($sformatf("nosplit c%0d memaddress", c), ma1, 32'h13);
         chk($sformatf("nosplit c%0d memdmctrl", c), {29'h0, mc1}, 32'h2);
         next_cycle();
      end
      drive(32'h0, 32'h0, 1'b0, 1'b0, 3'b000);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
